// File: rtl/modexp_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : modexp_ctrl_if
//  Description : Handshake bundle between the modular-exponentiation
//                controller and the Montgomery multiplier / exponent store.
//                master = controller side, slave = multiplier side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface modexp_ctrl_if;
    logic        mm_start;   // one-cycle launch pulse
    logic [1:0]  mm_op;      // 00 TOMONT, 01 SQR, 10 MUL, 11 FROMMONT
    logic        mm_dummy;   // MUL result is to be discarded
    logic        mm_done;    // one-cycle completion pulse
    logic [11:0] exp_idx;    // exponent bit address
    logic        exp_bit;    // exponent bit at exp_idx, same cycle

    modport master (
        output mm_start, mm_op, mm_dummy, exp_idx,
        input  mm_done, exp_bit
    );

    modport slave (
        input  mm_start, mm_op, mm_dummy, exp_idx,
        output mm_done, exp_bit
    );
endinterface
`default_nettype wire

// File: rtl/modexp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : modexp_ctrl
//  Description : Left-to-right square-and-multiply sequencer for a Montgomery
//                multiplier, with start-edge detection, abort, watchdog and
//                a registered status word.
//                Optional macro MODEXP_CTRL_DUMMY_MUL_EN: every exponent bit
//                takes SQR+MUL (dummy MUL for zero bits) and an LFSR inserts
//                0-3 idle cycles before each MUL launch.
//  Revision    : 1.0 - initial release
// ============================================================================
module modexp_ctrl #(
    parameter int S_AXI_DATA_WIDTH = 32,
    parameter int WDOG_MAX         = 65535
) (
    input  wire logic                        S_AXI_ACLK,
    input  wire logic                        S_AXI_ARESET,
    input  wire logic [S_AXI_DATA_WIDTH-1:0] CMD_register,
    input  wire logic [S_AXI_DATA_WIDTH-1:0] soft_reset,
    input  wire logic [S_AXI_DATA_WIDTH-1:0] random_seed,
    output logic      [S_AXI_DATA_WIDTH-1:0] STATE_register,
    output logic                             done_irq,
    modexp_ctrl_if.master                    mm
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SQR  = 3'd2,
        ST_MUL  = 3'd3,
        ST_NEXT = 3'd4,
        ST_POST = 3'd5,
        ST_DONE = 3'd6,
        ST_ERR  = 3'd7
    } state_t;

    localparam logic [1:0] OP_TOMONT   = 2'b00;
    localparam logic [1:0] OP_SQR      = 2'b01;
    localparam logic [1:0] OP_MUL      = 2'b10;
    localparam logic [1:0] OP_FROMMONT = 2'b11;
    localparam int         WDOG_W      = (WDOG_MAX < 2) ? 1 : $clog2(WDOG_MAX + 1);
    localparam logic [11:0] MAX_LEN    = 12'd2048;

    state_t              state_q;
    logic                start_q;      // registered copy of CMD_register[0]
    logic [11:0]         idx_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic                timeout_q;
    logic                mm_start_q;
    logic [1:0]          mm_op_q;
    logic                done_irq_q;
    logic                wait_q;       // a launched operation is outstanding
    logic [WDOG_W-1:0]   wdog_q;

    logic                rst;
    logic                start_edge;
    logic [11:0]         cmd_len;
    logic                len_ok;
    logic                abort_req;
    logic                done_ev;
    logic                wdog_exp;

    assign rst        = S_AXI_ARESET | soft_reset[0];
    assign start_edge = CMD_register[0] & ~start_q;
    assign cmd_len    = CMD_register[15:4];
    assign len_ok     = (cmd_len != 12'd0) && (cmd_len <= MAX_LEN);
    assign abort_req  = CMD_register[1] & busy_q;
    // mm_done only means something while an operation is outstanding
    assign done_ev    = mm.mm_done & wait_q;
    // Fires on the cycle the count would reach WDOG_MAX with no completion
    assign wdog_exp   = wait_q & ~mm.mm_done & (wdog_q == WDOG_W'(WDOG_MAX - 1));

`ifdef MODEXP_CTRL_DUMMY_MUL_EN
    logic        mm_dummy_q;
    logic [31:0] lfsr_q;
    logic [1:0]  dly_q;        // idle cycles still to insert before MUL launch

    // Fibonacci form of x^32 + x^22 + x^2 + x + 1
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction
`endif

    // Sequencer: state, status, launch handshake and watchdog
    always_ff @(posedge S_AXI_ACLK) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            idx_q      <= 12'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            timeout_q  <= 1'b0;
            mm_start_q <= 1'b0;
            mm_op_q    <= OP_TOMONT;
            done_irq_q <= 1'b0;
            wait_q     <= 1'b0;
            wdog_q     <= '0;
`ifdef MODEXP_CTRL_DUMMY_MUL_EN
            mm_dummy_q <= 1'b0;
            lfsr_q     <= 32'd0;
            dly_q      <= 2'd0;
`endif
        end else begin
            start_q    <= CMD_register[0];
            mm_start_q <= 1'b0;
            done_irq_q <= 1'b0;
            if (wait_q) begin
                wdog_q <= wdog_q + WDOG_W'(1);
            end

            if (abort_req) begin
                // abort wins over a same-cycle mm_done
                state_q    <= ST_ERR;
                busy_q     <= 1'b0;
                error_q    <= 1'b1;
                wait_q     <= 1'b0;
                done_irq_q <= 1'b1;
            end else if (wdog_exp) begin
                state_q    <= ST_ERR;
                busy_q     <= 1'b0;
                error_q    <= 1'b1;
                timeout_q  <= 1'b1;
                wait_q     <= 1'b0;
                done_irq_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE, ST_ERR: begin
                        if (start_edge) begin
                            done_q    <= 1'b0;
                            timeout_q <= 1'b0;
                            if (len_ok) begin
                                state_q    <= ST_PRE;
                                idx_q      <= cmd_len - 12'd1;
                                error_q    <= 1'b0;
                                busy_q     <= 1'b1;
                                mm_start_q <= 1'b1;
                                mm_op_q    <= OP_TOMONT;
                                wait_q     <= 1'b1;
                                wdog_q     <= '0;
`ifdef MODEXP_CTRL_DUMMY_MUL_EN
                                lfsr_q     <= (random_seed[31:0] == 32'd0) ? 32'd1
                                                                           : random_seed[31:0];
`endif
                            end else begin
                                state_q    <= ST_ERR;
                                error_q    <= 1'b1;
                                done_irq_q <= 1'b1;
                            end
                        end
                    end
                    ST_PRE: begin
                        if (done_ev) begin
                            state_q    <= ST_SQR;
                            mm_start_q <= 1'b1;
                            mm_op_q    <= OP_SQR;
                            wdog_q     <= '0;
                        end
                    end
                    ST_SQR: begin
                        if (done_ev) begin
                            wait_q <= 1'b0;
`ifdef MODEXP_CTRL_DUMMY_MUL_EN
                            state_q    <= ST_MUL;
                            mm_dummy_q <= ~mm.exp_bit;
                            lfsr_q     <= lfsr_step(lfsr_q);
                            if (lfsr_q[0] && (lfsr_q[2:1] != 2'd0)) begin
                                dly_q <= lfsr_q[2:1];
                            end else begin
                                mm_start_q <= 1'b1;
                                mm_op_q    <= OP_MUL;
                                wait_q     <= 1'b1;
                                wdog_q     <= '0;
                            end
`else
                            if (mm.exp_bit) begin
                                state_q    <= ST_MUL;
                                mm_start_q <= 1'b1;
                                mm_op_q    <= OP_MUL;
                                wait_q     <= 1'b1;
                                wdog_q     <= '0;
                            end else begin
                                state_q <= ST_NEXT;
                            end
`endif
                        end
                    end
                    ST_MUL: begin
`ifdef MODEXP_CTRL_DUMMY_MUL_EN
                        if (!wait_q) begin
                            // still burning inserted idle cycles
                            if (dly_q <= 2'd1) begin
                                dly_q      <= 2'd0;
                                mm_start_q <= 1'b1;
                                mm_op_q    <= OP_MUL;
                                wait_q     <= 1'b1;
                                wdog_q     <= '0;
                            end else begin
                                dly_q <= dly_q - 2'd1;
                            end
                        end else if (done_ev) begin
                            state_q    <= ST_NEXT;
                            wait_q     <= 1'b0;
                            mm_dummy_q <= 1'b0;
                        end
`else
                        if (done_ev) begin
                            state_q <= ST_NEXT;
                            wait_q  <= 1'b0;
                        end
`endif
                    end
                    ST_NEXT: begin
                        mm_start_q <= 1'b1;
                        wait_q     <= 1'b1;
                        wdog_q     <= '0;
                        if (idx_q == 12'd0) begin
                            state_q <= ST_POST;
                            mm_op_q <= OP_FROMMONT;
                        end else begin
                            state_q <= ST_SQR;
                            mm_op_q <= OP_SQR;
                            idx_q   <= idx_q - 12'd1;
                        end
                    end
                    ST_POST: begin
                        if (done_ev) begin
                            state_q    <= ST_DONE;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            wait_q     <= 1'b0;
                            done_irq_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        wait_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Status word is built purely from flops, so it is itself a register
    assign STATE_register = S_AXI_DATA_WIDTH'({idx_q, 9'd0, state_q,
                                               timeout_q, error_q, done_q, busy_q});
    assign done_irq       = done_irq_q;
    assign mm.mm_start    = mm_start_q;
    assign mm.mm_op       = mm_op_q;
    assign mm.exp_idx     = idx_q;
`ifdef MODEXP_CTRL_DUMMY_MUL_EN
    assign mm.mm_dummy    = mm_dummy_q;
`else
    assign mm.mm_dummy    = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{CMD_register[S_AXI_DATA_WIDTH-1:16], CMD_register[3:2],
                           soft_reset[S_AXI_DATA_WIDTH-1:1], random_seed};

endmodule
`default_nettype wire

// File: doc/modexp_ctrl.md
MODEXP_CTRL -- requirements
Module: modexp_ctrl

Interface
REQ-001 SHALL have parameter S_AXI_DATA_WIDTH, default 32, width of command/state words.
REQ-002 SHALL have parameter WDOG_MAX, default 65535, maximum cycles to wait for mm_done.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port S_AXI_ACLK, input, 1 bit, the only clock.
REQ-005 SHALL have port S_AXI_ARESET, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port CMD_register, input, 32 bits: [0] start, [1] abort, [15:4] exp_len.
REQ-007 SHALL have port soft_reset, input, 32 bits; only [0] is used.
REQ-008 SHALL have port random_seed, input, 32 bits; used only under MODEXP_CTRL_DUMMY_MUL_EN.
REQ-009 SHALL have port STATE_register, output, 32 bits: [0] busy, [1] done, [2] error, [3] timeout, [6:4] state, [27:16] exp_idx.
REQ-010 SHALL have port mm_start, output, 1 bit, one-cycle launch pulse to the Montgomery multiplier.
REQ-011 SHALL have port mm_op, output, 2 bits: 00 TOMONT, 01 SQR, 10 MUL, 11 FROMMONT.
REQ-012 SHALL have port mm_dummy, output, 1 bit, marks a MUL whose result is discarded.
REQ-013 SHALL have port mm_done, input, 1 bit, one-cycle completion pulse from the multiplier.
REQ-014 SHALL have port exp_idx, output, 12 bits, exponent bit address.
REQ-015 SHALL have port exp_bit, input, 1 bit, exponent bit at exp_idx, valid in the same cycle.
REQ-016 SHALL have port done_irq, output, 1 bit, one-cycle pulse when an operation ends.

Function
REQ-017 SHALL implement states IDLE=0, PRE=1, SQR=2, MUL=3, NEXT=4, POST=5, DONE=6, ERR=7.
REQ-018 SHALL detect start on a rising edge of CMD_register[0] (registered copy), because upstream auto-clears bit 0.
REQ-019 SHALL, in IDLE on a start edge with 1 <= exp_len <= 2048, load exp_idx = exp_len-1, clear done/error/timeout, and enter PRE.
REQ-020 SHALL, on a start edge with exp_len == 0 or exp_len > 2048, enter ERR with error=1 and never assert mm_start.
REQ-021 SHALL ignore start edges in any state other than IDLE, DONE, or ERR; DONE and ERR accept a start edge exactly as IDLE does.
REQ-022 SHALL assert mm_start for exactly one cycle on entry to PRE, SQR, MUL, and POST, with mm_op held stable until mm_done.
REQ-023 SHALL, in SQR on mm_done, go to MUL if exp_bit=1; otherwise go to NEXT.
REQ-024 SHALL, in MUL on mm_done, go to NEXT.
REQ-025 SHALL, in NEXT, go to POST if exp_idx==0; otherwise decrement exp_idx and go to SQR, with 1-cycle latency.
REQ-026 SHALL, in POST on mm_done, enter DONE, set done=1, and pulse done_irq.
REQ-027 SHALL keep busy=1 in PRE through POST, and busy=0 in IDLE, DONE, and ERR.
REQ-028 SHALL run a watchdog counter that is cleared at each mm_start; if it reaches WDOG_MAX before mm_done, SHALL enter ERR with error=1 and timeout=1.
REQ-029 SHALL, on CMD_register[1]=1 while busy, enter ERR with error=1 in the next cycle, and SHALL ignore any mm_done in that same cycle.
REQ-030 SHALL ignore mm_done while not waiting on a launched operation.
REQ-031 SHALL pulse done_irq once on entry to ERR.
REQ-032 SHALL drive STATE_register as a register updated every cycle.

Reset
REQ-033 SHALL, on S_AXI_ARESET=1 or soft_reset[0]=1 at a clock edge, force IDLE, exp_idx=0, all status bits 0, mm_start=0, mm_op=00, mm_dummy=0, done_irq=0, watchdog=0, and edge detector=0.
REQ-034 SHALL, on reset mid-operation, abandon the operation without a done_irq pulse.
REQ-035 SHALL hold soft_reset[0] reset for as long as it stays 1.

Configuration
REQ-036 SHALL, with macro MODEXP_CTRL_DUMMY_MUL_EN defined, go from SQR to MUL for exp_bit=0 as well, with mm_dummy=1, so every bit takes SQR+MUL.
REQ-037 SHALL, with the macro defined, include a 32-bit LFSR (poly x^32+x^22+x^2+x+1) seeded from random_seed on a start edge; when LFSR[0]=1, SHALL insert 0-3 idle cycles (LFSR[2:1]) before each MUL launch.
REQ-038 SHALL, with the macro undefined, tie mm_dummy to 0, omit the LFSR, and leave random_seed unused.

Verification
REQ-039 SHALL cover: exp_len=4, exp bits 1011 -> launch sequence TOMONT, SQR, MUL, SQR, SQR, MUL, SQR, MUL, FROMMONT; done=1; one done_irq pulse.
REQ-040 SHALL cover: exp_len=0, start -> ERR, error=1, no mm_start, one done_irq pulse.
REQ-041 SHALL cover: WDOG_MAX=16, mm_done withheld after SQR -> ERR at cycle 16 after mm_start, timeout=1.
REQ-042 SHALL cover: abort at 3rd SQR, then soft_reset[0] pulse -> ERR, then IDLE with STATE_register=0.
REQ-043 SHALL cover: start held high 10 cycles, second start edge while busy -> single operation only.
REQ-044 SHALL cover, with MODEXP_CTRL_DUMMY_MUL_EN: exp bits 00 -> 2 MULs, both with mm_dummy=1.
